// File: rtl/skid_pipe_reg.sv
// rtl/skid_pipe_reg.sv - two-entry skid pipeline register with registered in_ready.
// Optional stall counter output enabled by defining SKID_PIPE_REG_STATS_EN.
module skid_pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush
`ifdef SKID_PIPE_REG_STATS_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             rel;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready_q;
    assign rel       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && rel) begin
                    main_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (rel) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (rel) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        // Registered from the next state so in_ready never depends on out_ready combinationally.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef SKID_PIPE_REG_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = 16'h0000;
        end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: doc/skid_pipe_reg.md
SKID_PIPE_REG -- requirements
Module: skid_pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..64).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port in_valid  input  1  upstream offers in_data this cycle.
REQ-005 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-006 SHALL have port in_ready  output  1  stage can accept a word this cycle.
REQ-007 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-008 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the word this cycle.
REQ-010 SHALL have port flush  input  1  synchronous discard of all held words.

Function
REQ-011 SHALL be a two-entry pipeline register: a main entry (drives out_data) and a skid entry.
REQ-012 SHALL keep a 3-state FSM: EMPTY (no words), ONE (main full), FULL (main and skid full).
REQ-013 SHALL accept a word on an edge where in_valid=1 and in_ready=1.
REQ-014 SHALL release a word on an edge where out_valid=1 and out_ready=1.
REQ-015 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in FULL, from state registers only (no combinational path from out_ready).
REQ-016 SHALL drive out_valid = 1 in ONE and FULL and 0 in EMPTY.
REQ-017 SHALL transition EMPTY->ONE on accept, with in_data loaded into main; one-cycle latency in to out.
REQ-018 SHALL, in ONE, on accept and release together, load in_data into main and stay in ONE.
REQ-019 SHALL, in ONE, on accept without release, load in_data into skid and go to FULL.
REQ-020 SHALL, in ONE, on release without accept, go to EMPTY.
REQ-021 SHALL, in FULL, on release, move skid into main and go to ONE; no accept is possible in FULL.
REQ-022 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL preserve strict FIFO order; no word is duplicated or lost except by flush.
REQ-024 SHALL, on an edge with flush=1, go to EMPTY regardless of in_valid and out_ready; a simultaneous accept is dropped; flush has priority over all other events.
REQ-025 SHALL ignore in_data while in_valid=0 and in_data/in_valid while in_ready=0.

Reset
REQ-026 SHALL, while Reset=0, immediately force state EMPTY, in_ready=0, out_valid=0, out_data=0, skid=0.
REQ-027 SHALL, on Reset release, drive in_ready=1 from the first rising CLK edge onward; a word in flight when reset is asserted is lost.

Configuration
REQ-028 SHALL, when macro SKID_PIPE_REG_STATS_EN is defined, add output stall_cnt (16 bits): it counts edges with out_valid=1 and out_ready=0, saturates at 16'hFFFF, and is cleared by Reset and by flush.
REQ-029 SHALL, when SKID_PIPE_REG_STATS_EN is undefined, omit the stall_cnt port and its logic; the rest of the behaviour is identical.

Verification
REQ-030 SHALL cover pass-through: out_ready=1, in_valid=1 with data 1,2,3 on consecutive edges -> out_data 1,2,3 one cycle later, in_ready stays 1.
REQ-031 SHALL cover backpressure: out_ready=0, push 0xA then 0xB -> state FULL, in_ready=0, out_data=0xA held; raise out_ready -> 0xA, then 0xB, in order.
REQ-032 SHALL cover flush in FULL with in_valid=1 and data 0xC -> next edge out_valid=0, in_ready=1, 0xC never appears.
REQ-033 SHALL cover reset mid-operation: Reset=0 while in ONE, asynchronous to CLK -> out_valid=0 and out_data=0 before the next edge.
REQ-034 SHALL cover ONE with simultaneous accept 0x5 and release -> state stays ONE, out_data=0x5 next cycle.
REQ-035 SHALL cover, with SKID_PIPE_REG_STATS_EN defined, out_valid=1 and out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; then flush -> stall_cnt=0.
